// File: rtl/theta_pkg.sv
// Shared definitions for the slice-serial Keccak theta engine.
// Optional feature macro: THETA_INORDER_EN selects in-order emission
// (LOAD/EMIT FSM with full-state slice and parity buffers). When undefined,
// slices are emitted in the order 1..LANE_W-1, 0 (FIRST/STREAM/FLUSH FSM).
package theta_pkg;

    localparam int SLICE_W = 25;
    localparam int COLS    = 5;

`ifdef THETA_INORDER_EN
    localparam int STATE_W = 1;
    typedef enum logic [STATE_W-1:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } theta_state_e;
`else
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_FIRST  = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } theta_state_e;
`endif

    // Column parity of one slice: c[x] = XOR over y of slice[x + 5*y].
    function automatic logic [COLS-1:0] col_parity(input logic [SLICE_W-1:0] slice);
        logic [COLS-1:0] c;
        for (int x = 0; x < COLS; x++) begin
            c[x] = slice[x] ^ slice[x+5] ^ slice[x+10] ^ slice[x+15] ^ slice[x+20];
        end
        return c;
    endfunction

    // Theta mask for one slice, D[x] broadcast across all five rows.
    function automatic logic [SLICE_W-1:0] theta_d(input logic [COLS-1:0] c_cur,
                                                   input logic [COLS-1:0] c_prev);
        logic [COLS-1:0] d;
        for (int x = 0; x < COLS; x++) begin
            d[x] = c_cur[(x+4)%COLS] ^ c_prev[(x+1)%COLS];
        end
        return {COLS{d}};
    endfunction

endpackage

// File: rtl/theta_slice_mix.sv
// Combinational theta mix of one slice given its own column parity and the
// column parity of the preceding slice (z-1, wrapping).
module theta_slice_mix
    import theta_pkg::*;
(
    input  logic [SLICE_W-1:0] slice_i,
    input  logic [COLS-1:0]    c_cur_i,
    input  logic [COLS-1:0]    c_prev_i,
    output logic [SLICE_W-1:0] slice_o
);

    // XOR the broadcast D mask into the slice.
    assign slice_o = slice_i ^ theta_d(c_cur_i, c_prev_i);

endmodule

// File: rtl/theta_slice_stream.sv
// Slice-serial Keccak theta engine with valid/ready streaming on both sides.
// Optional feature macro: THETA_INORDER_EN (in-order emission with full-state
// buffering). Default build: reordered emission 1..LANE_W-1 then 0, holding
// only slice 0 and two parity words.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Valid
// never depends on ready; while out_valid && !out_ready the output register
// (out_slice, out_idx, out_last) holds its contents unchanged.
module theta_slice_stream
    import theta_pkg::*;
#(
    parameter  int LANE_W = 64,
    localparam int IDX_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               busy,
    output logic [STATE_W-1:0] dbg_state_o
);

    localparam logic [IDX_W-1:0] LAST_Z = IDX_W'(LANE_W - 1);
    localparam logic [IDX_W-1:0] ONE_Z  = (LANE_W > 1) ? IDX_W'(1) : '0;

    theta_state_e       state_q, state_d;
    logic [IDX_W-1:0]   z_q, z_d;
    logic               out_valid_q, out_valid_d;
    logic [SLICE_W-1:0] out_slice_q, out_slice_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;

    logic [COLS-1:0]    in_par;
    logic               out_free;
    logic [SLICE_W-1:0] mix_slice;
    logic [COLS-1:0]    mix_cur;
    logic [COLS-1:0]    mix_prev;
    logic [SLICE_W-1:0] mix_out;

    assign in_par   = col_parity(in_slice);
    assign out_free = !out_valid_q || out_ready;

    theta_slice_mix u_mix (
        .slice_i  (mix_slice),
        .c_cur_i  (mix_cur),
        .c_prev_i (mix_prev),
        .slice_o  (mix_out)
    );

`ifdef THETA_INORDER_EN

    logic [SLICE_W-1:0] sbuf_q [LANE_W];
    logic [COLS-1:0]    pbuf_q [LANE_W];
    logic               buf_we;
    logic [IDX_W-1:0]   prev_z;

    assign prev_z = (z_q == '0) ? LAST_Z : (z_q - ONE_Z);

    // Capture incoming slices and their column parities at their own index.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            sbuf_q[z_q] <= in_slice;
            pbuf_q[z_q] <= in_par;
        end
    end

    // LOAD collects a full state; slice 0 output is produced on the last
    // accept when the output register is free, otherwise EMIT starts at 0.
    always_comb begin
        state_d     = state_q;
        z_d         = z_q;
        out_valid_d = out_valid_q && !out_ready;
        out_slice_d = out_slice_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        buf_we      = 1'b0;
        mix_slice   = sbuf_q[z_q];
        mix_cur     = pbuf_q[z_q];
        mix_prev    = pbuf_q[prev_z];
        unique case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we = 1'b1;
                    z_d    = z_q + ONE_Z;
                    if (z_q == LAST_Z) begin
                        z_d     = '0;
                        state_d = ST_EMIT;
                        if (out_free) begin
                            // Slice 0 mixes against the slice arriving now.
                            mix_slice   = (LANE_W == 1) ? in_slice : sbuf_q[0];
                            mix_cur     = (LANE_W == 1) ? in_par   : pbuf_q[0];
                            mix_prev    = in_par;
                            out_valid_d = 1'b1;
                            out_slice_d = mix_out;
                            out_idx_d   = '0;
                            out_last_d  = (LANE_W == 1);
                            z_d         = ONE_Z;
                            state_d     = (LANE_W == 1) ? ST_LOAD : ST_EMIT;
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_slice_d = mix_out;
                    out_idx_d   = z_q;
                    out_last_d  = (z_q == LAST_Z);
                    z_d         = z_q + ONE_Z;
                    if (z_q == LAST_Z) begin
                        z_d     = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                z_d     = '0;
            end
        endcase
    end

    assign busy = (state_q != ST_LOAD) || (z_q != '0) || out_valid_q;

    // FSM, index counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            z_q         <= '0;
            out_valid_q <= 1'b0;
            out_slice_q <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
            out_slice_q <= out_slice_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

`else

    logic [SLICE_W-1:0] slice0_q, slice0_d;
    logic [COLS-1:0]    c0_q, c0_d;
    logic [COLS-1:0]    cprev_q, cprev_d;

    // FIRST parks slice 0, STREAM emits 1..LANE_W-1 as they arrive, FLUSH
    // emits slice 0 once C_{LANE_W-1} is known.
    always_comb begin
        state_d     = state_q;
        z_d         = z_q;
        slice0_d    = slice0_q;
        c0_d        = c0_q;
        cprev_d     = cprev_q;
        out_valid_d = out_valid_q && !out_ready;
        out_slice_d = out_slice_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        mix_slice   = in_slice;
        mix_cur     = in_par;
        mix_prev    = cprev_q;
        unique case (state_q)
            ST_FIRST: begin
                // Ready even while the previous slice 0 is still held.
                in_ready = 1'b1;
                if (in_valid) begin
                    slice0_d = in_slice;
                    c0_d     = in_par;
                    cprev_d  = in_par;
                    z_d      = ONE_Z;
                    state_d  = (LANE_W == 1) ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready = out_free;
                if (in_valid && out_free) begin
                    out_valid_d = 1'b1;
                    out_slice_d = mix_out;
                    out_idx_d   = z_q;
                    out_last_d  = 1'b0;
                    cprev_d     = in_par;
                    z_d         = z_q + ONE_Z;
                    if (z_q == LAST_Z) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                mix_slice = slice0_q;
                mix_cur   = c0_q;
                mix_prev  = cprev_q;
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_slice_d = mix_out;
                    out_idx_d   = '0;
                    out_last_d  = 1'b1;
                    z_d         = '0;
                    state_d     = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_FIRST;
                z_d     = '0;
            end
        endcase
    end

    assign busy = (state_q != ST_FIRST) || out_valid_q;

    // FSM, slice 0 / parity storage and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FIRST;
            z_q         <= '0;
            slice0_q    <= '0;
            c0_q        <= '0;
            cprev_q     <= '0;
            out_valid_q <= 1'b0;
            out_slice_q <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            slice0_q    <= slice0_d;
            c0_q        <= c0_d;
            cprev_q     <= cprev_d;
            out_valid_q <= out_valid_d;
            out_slice_q <= out_slice_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

`endif

    assign out_valid   = out_valid_q;
    assign out_slice   = out_slice_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_last_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_theta_slice_stream.sv
// Bench for theta_slice_stream: one instance with LANE_W=4 and one with
// LANE_W=1, directed table vectors, hand-written stall/reset/latency
// sequences and a randomized run against a whole-state reference model.
module tb_theta_slice_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_last4, busy4;
  logic [24:0] in_slice4 = '0, out_slice4;
  logic [1:0]  out_idx4;
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, out_last1, busy1;
  logic [24:0] in_slice1 = '0, out_slice1;
  logic [0:0]  out_idx1;
  logic [theta_pkg::STATE_W-1:0] dbg4, dbg1;

  int checks = 0;
  int errors = 0;
  bit rnd_en = 1'b0;

  // scoreboard: expected and observed {last, idx[5:0], slice} words
  logic [31:0] exp4[$], got4[$], exp1[$], got1[$];
  logic [24:0] part4[$], part1[$];

  typedef struct {
    logic [24:0] in_s[4];
    logic [24:0] exp_z[4];
  } vec_t;
  vec_t tbl[3];

  theta_slice_stream #(.LANE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_slice(in_slice4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_slice(out_slice4), .out_idx(out_idx4),
    .out_last(out_last4), .busy(busy4), .dbg_state_o(dbg4)
  );

  theta_slice_stream #(.LANE_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_slice(in_slice1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_slice(out_slice1), .out_idx(out_idx1),
    .out_last(out_last1), .busy(busy1), .dbg_state_o(dbg1)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [24:0] ref_out(input logic [24:0] s[$], input int z);
    int lw, zp;
    logic [4:0] c, cp;
    logic [24:0] r, cur, prv;
    lw = s.size();
    zp = (z + lw - 1) % lw;
    cur = s[z];
    prv = s[zp];
    for (int x = 0; x < 5; x++) begin
      c[x] = 1'b0;
      cp[x] = 1'b0;
      for (int y = 0; y < 5; y++) begin
        c[x] = c[x] ^ cur[x+5*y];
        cp[x] = cp[x] ^ prv[x+5*y];
      end
    end
    r = cur;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x+5*y] = r[x+5*y] ^ c[(x+4)%5] ^ cp[(x+1)%5];
    return r;
  endfunction

  // k-th emitted slice of a state
  function automatic int emit_z(input int k, input int lw);
`ifdef THETA_INORDER_EN
    return k;
`else
    return (k + 1) % lw;
`endif
  endfunction

  function automatic bit is_last(input int z, input int lw);
`ifdef THETA_INORDER_EN
    return z == lw - 1;
`else
    return z == 0;
`endif
  endfunction

  function automatic logic [31:0] pack(input bit l, input int z, input logic [24:0] v);
    return {l, 6'(z), v};
  endfunction

  task automatic model_accept(input int which, input logic [24:0] s);
    int z;
    if (which == 4) begin
      part4.push_back(s);
      if (part4.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          z = emit_z(k, 4);
          exp4.push_back(pack(is_last(z, 4), z, ref_out(part4, z)));
        end
        part4.delete();
      end
    end else begin
      part1.push_back(s);
      exp1.push_back(pack(1'b1, 0, ref_out(part1, 0)));
      part1.delete();
    end
  endtask

  // monitor: handshakes seen at negedge complete on the following posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid4 && in_ready4) model_accept(4, in_slice4);
      if (in_valid1 && in_ready1) model_accept(1, in_slice1);
      if (out_valid4 && out_ready4) got4.push_back({out_last4, 6'(out_idx4), out_slice4});
      if (out_valid1 && out_ready1) got1.push_back({out_last1, 6'(out_idx1), out_slice1});
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        out_ready4 = ($urandom_range(0, 3) != 0);
        out_ready1 = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // caller is at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int which, input logic [24:0] s);
    int n;
    n = 0;
    if (which == 4) begin in_valid4 = 1'b1; in_slice4 = s; end
    else begin in_valid1 = 1'b1; in_slice1 = s; end
    @(negedge clk);
    while (!((which == 4) ? in_ready4 : in_ready1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    if (which == 4) in_valid4 = 1'b0;
    else in_valid1 = 1'b0;
  endtask

  // wait for all expected outputs, then check busy drops
  task automatic drain(input int which, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (n < 500 && ((which == 4) ? (part4.size() != 0 || got4.size() < exp4.size())
                                    : (part1.size() != 0 || got1.size() < exp1.size()))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk({nm, "_drain_timeout"}, 32'(n), 32'(0));
    @(negedge clk);
    if (which == 4) chk({nm, "_busy"}, 32'(busy4), 32'(0));
    else chk({nm, "_busy"}, 32'(busy1), 32'(0));
  endtask

  task automatic sb(input int which, input string nm);
    if (which == 4) begin
      chk({nm, "_count"}, 32'(got4.size()), 32'(exp4.size()));
      while (got4.size() > 0 && exp4.size() > 0) chk({nm, "_data"}, got4.pop_front(), exp4.pop_front());
      got4.delete(); exp4.delete();
    end else begin
      chk({nm, "_count"}, 32'(got1.size()), 32'(exp1.size()));
      while (got1.size() > 0 && exp1.size() > 0) chk({nm, "_data"}, got1.pop_front(), exp1.pop_front());
      got1.delete(); exp1.delete();
    end
  endtask

  task automatic tbl_check(input int i, input string nm);
    int z;
    for (int k = 0; k < 4; k++) begin
      z = emit_z(k, 4);
      if (got4.size() > k)
        chk($sformatf("%s_k%0d", nm, k), got4[k], pack(is_last(z, 4), z, tbl[i].exp_z[z]));
      else
        chk($sformatf("%s_k%0d_missing", nm, k), 32'(got4.size()), 32'(k + 1));
    end
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] held;
  int n;

  initial begin
    tbl[0].in_s  = '{25'h0, 25'h0, 25'h0, 25'h0};
    tbl[0].exp_z = '{25'h0, 25'h0, 25'h0, 25'h0};
    tbl[1].in_s  = '{25'h0000001, 25'h0, 25'h0, 25'h0};
    tbl[1].exp_z = '{25'h0210843, 25'h1084210, 25'h0, 25'h0};
    tbl[2].in_s  = '{25'h0, 25'h0000001, 25'h0, 25'h0};
    tbl[2].exp_z = '{25'h0, 25'h0210843, 25'h1084210, 25'h0};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid4), 32'(0));
    chk("rst_out_slice", 32'(out_slice4), 32'(0));
    chk("rst_out_idx", 32'(out_idx4), 32'(0));
    chk("rst_out_last", 32'(out_last4), 32'(0));
    chk("rst_busy", 32'(busy4), 32'(0));
    chk("rst_lw1_valid_busy", {30'd0, out_valid1, busy1}, 32'(0));
    to_drive();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready4), 32'(1));
    chk("rst_lw1_in_ready", 32'(in_ready1), 32'(1));

    // latency sequence, slice0 = 1
    to_drive();
    send(4, 25'h1);
    @(negedge clk);
    chk("lat_s0_no_out", 32'(out_valid4), 32'(0));
    to_drive();
    send(4, 25'h0);
    @(negedge clk);
`ifndef THETA_INORDER_EN
    chk("lat_s1_valid", {29'd0, out_valid4, out_idx4}, {29'd0, 1'b1, 2'd1});
`endif
    to_drive();
    send(4, 25'h0);
    send(4, 25'h0);
    @(negedge clk);
`ifdef THETA_INORDER_EN
    chk("lat_first_out", {28'd0, out_valid4, out_idx4, out_last4}, {28'd0, 1'b1, 2'd0, 1'b0});
`else
    chk("lat_s3_valid", {28'd0, out_valid4, out_idx4, out_last4}, {28'd0, 1'b1, 2'd3, 1'b0});
    @(negedge clk);
    chk("lat_flush", {28'd0, out_valid4, out_idx4, out_last4}, {28'd0, 1'b1, 2'd0, 1'b1});
`endif
    drain(4, "lat");
    tbl_check(1, "lat_tbl");
    sb(4, "lat");

    // table vectors, full throughput
    for (int i = 0; i < 3; i++) begin
      to_drive();
      out_ready4 = 1'b1;
      for (int z = 0; z < 4; z++) send(4, tbl[i].in_s[z]);
      drain(4, $sformatf("tbl%0d", i));
      tbl_check(i, $sformatf("tbl%0d", i));
      sb(4, $sformatf("tbl%0d", i));
    end

    // stall: out_ready low for 5 cycles after first out_valid
    to_drive();
    out_ready4 = 1'b0;
    fork
      begin
        for (int z = 0; z < 4; z++) send(4, tbl[1].in_s[z]);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid4 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("stall_wait_timeout", 32'(n), 32'(0));
        held = {out_last4, 6'(out_idx4), out_slice4};
`ifdef THETA_INORDER_EN
        chk("stall_first", held, pack(1'b0, 0, 25'h0210843));
`else
        chk("stall_first", held, pack(1'b0, 1, 25'h1084210));
`endif
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk($sformatf("stall_hold%0d", c), {out_last4, 6'(out_idx4), out_slice4}, held);
          chk($sformatf("stall_valid%0d", c), 32'(out_valid4), 32'(1));
          chk($sformatf("stall_in_ready%0d", c), 32'(in_ready4), 32'(0));
        end
        to_drive();
        out_ready4 = 1'b1;
      end
    join
    drain(4, "stall");
    tbl_check(1, "stall_tbl");
    sb(4, "stall");

    // reset mid-state after two accepted slices
    to_drive();
    send(4, 25'(($urandom() | 32'h1)));
    send(4, 25'($urandom()));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    part4.delete(); exp4.delete(); got4.delete();
    chk("midrst_out_valid", 32'(out_valid4), 32'(0));
    chk("midrst_out_slice", 32'(out_slice4), 32'(0));
    chk("midrst_idx_last", {29'd0, out_idx4, out_last4}, 32'(0));
    chk("midrst_busy", 32'(busy4), 32'(0));
    to_drive();
    rst_n = 1'b1;
    to_drive();
    send(4, 25'h1);
    @(negedge clk);
    chk("midrst_s0_no_out", 32'(out_valid4), 32'(0));
    to_drive();
    for (int z = 1; z < 4; z++) send(4, 25'h0);
    drain(4, "midrst");
    tbl_check(1, "midrst_tbl");
    sb(4, "midrst");

    // LANE_W = 1
    to_drive();
    send(1, 25'h1);
    drain(1, "lw1");
    if (got1.size() > 0) chk("lw1_value", got1[0], pack(1'b1, 0, 25'h1294A53));
    else chk("lw1_missing", 32'(got1.size()), 32'(1));
    sb(1, "lw1");

    // randomized stimulus with random backpressure on both instances
    to_drive();
    rnd_en = 1'b1;
    fork
      begin
        for (int s = 0; s < 24; s++) begin
          repeat ($urandom_range(0, 2)) to_drive();
          send(4, 25'($urandom()));
        end
      end
      begin
        for (int s = 0; s < 10; s++) begin
          repeat ($urandom_range(0, 3)) to_drive();
          send(1, 25'($urandom()));
        end
      end
    join
    drain(4, "rnd4");
    drain(1, "rnd1");
    sb(4, "rnd4");
    sb(1, "rnd1");
    rnd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/theta_slice_stream.md
# theta_slice_stream

Slice-serial Keccak theta engine. Accepts one 25-bit state slice per transfer, LANE_W slices per permutation state. Applies the full theta column-parity mix, including the wrap-around dependency between the last slice and slice 0. Sits between the slice-ordered state buffer and the rho/pi stage of the parametrised permutation datapath. It replaces the fixed two-slice combinational mixer with a streaming, backpressured, lane-width-generic block.

## Interface
- LANE_W, 64: slices per state; power of two, 1..64 (state = 25·LANE_W bits).
- IDX_W, max(1,$clog2(LANE_W)): derived localparam, slice index width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input slice valid.
- in_ready  out  1  block accepts the input slice this cycle.
- in_slice  in  25  slice z; bit i = x+5·y.
- out_valid  out  1  output slice valid.
- out_ready  in  1  downstream accepts the output slice.
- out_slice  out  25  theta-mixed slice.
- out_idx  out  IDX_W  z of out_slice.
- out_last  out  1  final output slice of the state.
- busy  out  1  state partially accepted or not yet fully emitted.

## Operation
- Transfer occurs when valid && ready. Slice index z is counted internally from 0 and wraps after LANE_W-1.
- C_z[x] = XOR over y of slice_z[x+5y]. D_z[x] = C_z[(x+4)%5] ^ C_{z-1}[(x+1)%5], where z-1 wraps to LANE_W-1. out = slice_z ^ D_z, with D broadcast across all five rows.
- Default order: 1..LANE_W-1, then 0.
- FSM states are FIRST, STREAM, FLUSH.
- FIRST: in_ready=1. Accepting slice 0 stores slice0 and C_0, stores C_prev=C_0, and produces no output. Next state is STREAM, or FLUSH if LANE_W=1.
- STREAM: in_ready = !out_valid || out_ready. Accepting slice z loads the output register with {slice_z^D_z, z, 0} and sets C_prev=C_z. Accepting z=LANE_W-1 moves to FLUSH.
- FLUSH: in_ready=0. When the output register is free or being taken, it loads {slice0^D_0, 0, 1}, using C_0 and C_prev=C_{LANE_W-1}. On load, the FSM returns to FIRST.
- The output register holds out_slice, out_idx and out_last stable while out_valid && !out_ready.
- busy = (state != FIRST) || out_valid.
- For LANE_W=1, C_{z-1}=C_0.
- Reset mid-state: all partial state is discarded. The next accepted slice is slice 0.

## Timing
- Reset values: out_valid=0, out_slice=0, out_idx=0, out_last=0, busy=0. in_ready=1 after reset.
- Default latency: slice z≥1 accepted at edge t gives out_valid at t+1.
- Slice 0 output appears 1 cycle after the slice LANE_W-1 entry leaves the output register, or at t+2 after the last accept if no stall.
- Full-throughput ordering is 1 slice/cycle in STREAM, plus 1 FLUSH cycle per state.
- In FIRST, in_ready=1 even while a previous state's slice 0 is still held. This allows back-to-back states with no bubble.
- When a full output register is taken and a new input is accepted in the same cycle, the register is reloaded with no gap.

## Configuration
- THETA_INORDER_EN defined: adds a LANE_W×25 slice buffer and a LANE_W×5 parity buffer. The FSM becomes LOAD/EMIT.
  - LOAD: in_ready=1, accepting LANE_W slices.
  - EMIT: in_ready=0, emitting z=0..LANE_W-1 in order, one per handshake, with out_last on z=LANE_W-1.
  - First out_valid comes 1 cycle after the last accept.
- THETA_INORDER_EN undefined: default reordered streaming with only one slice of storage.
- Output values for every z are identical in both modes. Only order and latency differ.

## Structure
- Package theta_pkg holds:
  - SLICE_W=25 and COLS=5.
  - Function col_parity(slice) → 5 bits.
  - Function theta_d(c_cur, c_prev) → 25-bit broadcast mask.
  - The FSM state enum.
- One combinational sub-module, theta_slice_mix (slice, c_cur, c_prev → mixed slice), shared by the STREAM and FLUSH paths.

## Test plan
- LANE_W=4, all-zero slices, out_ready=1 → four outputs of 0, out_idx 1,2,3,0, out_last only on idx 0, busy low after the fourth transfer.
- LANE_W=4, slice0=25'h0000001, others 0 → idx1=25'h1084210, idx2=0, idx3=0, idx0=25'h0210843.
- Same stimulus with out_ready low for 5 cycles after the first out_valid → out_slice/out_idx stable, in_ready=0, no slice lost or duplicated.
- rst_n pulsed low after 2 accepted slices → outputs return to reset values immediately; next slice 25'h0000001 is treated as slice 0 with no output.
- LANE_W=1, slice 25'h0000001 → single output 25'h1294A53, out_idx=0, out_last=1.
- THETA_INORDER_EN, LANE_W=4, stimulus as in the second case → order idx 0,1,2,3 with values 25'h0210843, 25'h1084210, 0, 0, and out_last on idx 3.
